// File: rtl/topk_stream_tracker.sv
// Streaming top-K tracker.
// Keeps the K largest samples seen since reset/clear, sorted descending (entry 0 = largest),
// together with each entry's arrival index. Equal values never displace, so earlier samples
// rank higher among ties. Empty entries behave as -infinity and always read as zero.
//
// Ports:
//   clk        clock, all state updates on posedge
//   reset      asynchronous, active-high
//   clear      synchronous flush of table and counters (a same-cycle sample is kept)
//   in_valid   in_data carries a sample this cycle
//   in_data    sample value
//   top_data   entry i at [i*WIDTH +: WIDTH]
//   top_idx    arrival index of entry i at [i*IDX_W +: IDX_W]
//   top_vld    bit i set = entry i occupied
//   sample_cnt accepted samples since reset/clear, saturating
//   updated    pulse: table changed on the previous edge
module topk_stream_tracker #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned K      = 3,
    parameter bit          SIGNED = 1'b1,
    parameter int unsigned IDX_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic [K*WIDTH-1:0]   top_data,
    output logic [K*IDX_W-1:0]   top_idx,
    output logic [K-1:0]         top_vld,
    output logic [IDX_W-1:0]     sample_cnt,
    output logic                 updated
);

    logic [WIDTH-1:0] data_q [K];
    logic [WIDTH-1:0] data_d [K];
    logic [IDX_W-1:0] idx_q  [K];
    logic [IDX_W-1:0] idx_d  [K];
    logic [K-1:0]     vld_q, vld_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] arr_q, arr_d;
    logic             upd_q, upd_d;

    // Table as seen after an optional clear; insertion is applied on top of it.
    logic [WIDTH-1:0] base_data [K];
    logic [IDX_W-1:0] base_idx  [K];
    logic [K-1:0]     base_vld;
    logic [IDX_W-1:0] base_cnt;
    logic [IDX_W-1:0] base_arr;

    // Neighbour (i-1) views, so the shift needs no out-of-range index at i = 0.
    logic [WIDTH-1:0] prev_data [K];
    logic [IDX_W-1:0] prev_idx  [K];
    logic [K-1:0]     prev_vld;
    logic [K-1:0]     ins;
    logic [K-1:0]     prev_ins;

    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            base_data[i] = clear ? '0 : data_q[i];
            base_idx[i]  = clear ? '0 : idx_q[i];
        end
        base_vld = clear ? '0 : vld_q;
        base_cnt = clear ? '0 : cnt_q;
        base_arr = clear ? '0 : arr_q;

        // Because the table is sorted and fills in order, ins is a thermometer code:
        // once a slot qualifies, every lower-ranked slot does too.
        for (int unsigned i = 0; i < K; i++) begin
            if (SIGNED) begin
                ins[i] = !base_vld[i] || ($signed(in_data) > $signed(base_data[i]));
            end else begin
                ins[i] = !base_vld[i] || (in_data > base_data[i]);
            end
        end

        prev_data[0] = '0;
        prev_idx[0]  = '0;
        prev_vld[0]  = 1'b0;
        prev_ins[0]  = 1'b0;
        for (int unsigned i = 1; i < K; i++) begin
            prev_data[i] = base_data[i-1];
            prev_idx[i]  = base_idx[i-1];
            prev_vld[i]  = base_vld[i-1];
            prev_ins[i]  = ins[i-1];
        end

        for (int unsigned i = 0; i < K; i++) begin
            data_d[i] = base_data[i];
            idx_d[i]  = base_idx[i];
            vld_d[i]  = base_vld[i];
            if (in_valid && ins[i]) begin
                if (!prev_ins[i]) begin
                    // Insertion point p.
                    data_d[i] = in_data;
                    idx_d[i]  = base_arr;
                    vld_d[i]  = 1'b1;
                end else begin
                    data_d[i] = prev_data[i];
                    idx_d[i]  = prev_idx[i];
                    vld_d[i]  = prev_vld[i];
                end
            end
        end

        arr_d = base_arr;
        cnt_d = base_cnt;
        if (in_valid) begin
            arr_d = base_arr + 1'b1;
            if (base_cnt != '1) begin
                cnt_d = base_cnt + 1'b1;
            end
        end

        upd_d = clear || (in_valid && (|ins));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < K; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
            arr_q <= '0;
            upd_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < K; i++) begin
                data_q[i] <= data_d[i];
                idx_q[i]  <= idx_d[i];
            end
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            arr_q <= arr_d;
            upd_q <= upd_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < K; i++) begin
            top_data[i*WIDTH +: WIDTH] = data_q[i];
            top_idx[i*IDX_W +: IDX_W]  = idx_q[i];
        end
    end

    assign top_vld    = vld_q;
    assign sample_cnt = cnt_q;
    assign updated    = upd_q;

endmodule
